// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg
//   Shared definitions for the multi-channel timer peripheral: register map
//   offsets, packed views of the per-channel CR/SR registers, channel FSM
//   state constants and the address validity check used by the bus decoder.
package multi_timer_pkg;

  // Global registers
  localparam logic [11:0] OFF_PRESC   = 12'h000;
  localparam logic [11:0] OFF_IRQSR   = 12'h004;

  // Channel n lives at OFF_CH_BASE + CH_STRIDE*n
  localparam logic [11:0] OFF_CH_BASE = 12'h100;
  localparam logic [11:0] CH_STRIDE   = 12'h010;

  // Register offsets inside a channel window
  localparam logic [3:0]  OFF_CR      = 4'h0;
  localparam logic [3:0]  OFF_SR      = 4'h4;
  localparam logic [3:0]  OFF_CNT     = 4'h8;
  localparam logic [3:0]  OFF_CMP     = 4'hC;

  // Channel FSM states (act = ST_RUN)
  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_RUN      = 1'b1;

  typedef struct packed {
    logic ie;
    logic per;
    logic hlt;
    logic trg;
  } ch_cr_t;

  typedef struct packed {
    logic mtch;
    logic act;
  } ch_sr_t;

  // A byte offset is valid if it hits one of the two global registers, or a
  // word-aligned register inside the window of an implemented channel.
  function automatic logic is_offset_valid(input logic [11:0] addr, input int num_ch);
    logic [11:0] ch_end;
    ch_end = OFF_CH_BASE + CH_STRIDE * 12'(num_ch);
    if (addr == OFF_PRESC || addr == OFF_IRQSR) begin
      return 1'b1;
    end
    return (addr >= OFF_CH_BASE) && (addr < ch_end) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// multi_timer_channel
//   One timer channel: control/status/count/compare registers, the IDLE/RUN
//   FSM and the match / auto-reload logic.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   tick       shared prescaler tick (1 cycle)
//   cr_we      write strobe for CR  (trg, hlt, per, ie)
//   sr_we      write strobe for SR  (bit 1 is write-one-to-clear mtch)
//   cnt_we     write strobe for CNT
//   cmp_we     write strobe for CMP
//   wdata      bus write data
//   cr, sr     register views for readback (trg/hlt always read 0)
//   cnt, cmp   counter and compare value
//   irq        mtch & ie
module multi_timer_channel import multi_timer_pkg::*; #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             cr_we,
  input  logic             sr_we,
  input  logic             cnt_we,
  input  logic             cmp_we,
  input  logic [31:0]      wdata,
  output ch_cr_t           cr,
  output ch_sr_t           sr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cmp,
  output logic             irq
);

  logic [0:0] state;
  logic       per;
  logic       ie;
  logic       mtch;
  logic       trg;
  logic       hlt;
  logic       match;

  // trg and hlt act directly at the write edge and are never stored, so they
  // are gone the cycle after the write and always read back as 0.
  assign trg = cr_we & wdata[0];
  assign hlt = cr_we & wdata[1];

  // A control write (trg or hlt) takes precedence over a tick in that cycle.
  assign match = (state == ST_RUN) & tick & ~(trg | hlt) & (cnt == cmp);

  // FSM and counter. hlt beats trg; a software CNT write beats the increment
  // or reload in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      if (hlt) begin
        state <= ST_IDLE;
      end else if (trg) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else if (match) begin
        if (per) begin
          cnt <= '0;
        end else begin
          state <= ST_IDLE;
        end
      end else if ((state == ST_RUN) && tick) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (cnt_we) begin
        cnt <= wdata[CNT_W-1:0];
      end
    end
  end

  // Configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per <= 1'b0;
      ie  <= 1'b0;
      cmp <= '0;
    end else begin
      if (cr_we) begin
        per <= wdata[2];
        ie  <= wdata[3];
      end
      if (cmp_we) begin
        cmp <= wdata[CNT_W-1:0];
      end
    end
  end

  // Match flag: a hardware match in the same cycle as a W1C keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtch <= 1'b0;
    end else if (match) begin
      mtch <= 1'b1;
    end else if (sr_we && wdata[1]) begin
      mtch <= 1'b0;
    end
  end

  assign cr  = '{ie: ie, per: per, hlt: 1'b0, trg: 1'b0};
  assign sr  = '{mtch: mtch, act: (state == ST_RUN)};
  assign irq = mtch & ie;

endmodule

// File: rtl/multi_timer.sv
// multi_timer
//   Multi-channel timer peripheral on a req/gnt data bus. NUM_CH counters
//   share one programmable prescaler; each channel raises a match flag and an
//   optional interrupt. Channel IRQs are ORed into a single line.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   req, we    bus request and write enable
//   addr       byte offset within the peripheral
//   wdata      write data
//   gnt        grant (combinational copy of req)
//   rvalid     response valid, one cycle after gnt
//   err        invalid offset, returned with rvalid
//   rdata      registered read data
//   irq        OR of all channel IRQs
//   irq_vec    per-channel IRQ (mtch & ie)
module multi_timer import multi_timer_pkg::*; #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [11:0]       addr,
  input  logic [31:0]       wdata,
  output logic              gnt,
  output logic              rvalid,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  logic               addr_valid;
  logic               wr;
  logic               is_ch;
  logic [2:0]         ch_idx;
  logic               presc_we;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               any_act;
  logic               tick;
  logic [31:0]        rd_mux;

  ch_cr_t             ch_cr  [NUM_CH];
  ch_sr_t             ch_sr  [NUM_CH];
  logic [CNT_W-1:0]   ch_cnt [NUM_CH];
  logic [CNT_W-1:0]   ch_cmp [NUM_CH];
  logic [NUM_CH-1:0]  ch_act;
  logic [NUM_CH-1:0]  ch_irq;

  assign gnt        = req;
  assign addr_valid = is_offset_valid(addr, NUM_CH);
  assign wr         = req & we & addr_valid;
  assign is_ch      = (addr[11:8] == OFF_CH_BASE[11:8]);
  assign ch_idx     = addr[6:4];
  assign presc_we   = wr & (addr == OFF_PRESC);

  // Prescaler only advances while some channel is running, so an idle
  // peripheral keeps its phase. Writing PRESC restarts the phase at 0.
  assign any_act = |ch_act;
  assign tick    = any_act & (presc_cnt == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else if (presc_we) begin
      presc     <= wdata[PRESC_W-1:0];
      presc_cnt <= '0;
    end else if (any_act) begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic ch_sel;
    assign ch_sel = wr & is_ch & (ch_idx == 3'(n));

    multi_timer_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .cr_we  (ch_sel & (addr[3:0] == OFF_CR)),
      .sr_we  (ch_sel & (addr[3:0] == OFF_SR)),
      .cnt_we (ch_sel & (addr[3:0] == OFF_CNT)),
      .cmp_we (ch_sel & (addr[3:0] == OFF_CMP)),
      .wdata  (wdata),
      .cr     (ch_cr[n]),
      .sr     (ch_sr[n]),
      .cnt    (ch_cnt[n]),
      .cmp    (ch_cmp[n]),
      .irq    (ch_irq[n])
    );

    assign ch_act[n] = ch_sr[n].act;
  end

  assign irq_vec = ch_irq;
  assign irq     = |ch_irq;

  // Readback mux; every register is zero-extended to 32 bits
  always_comb begin
    rd_mux = '0;
    if (addr == OFF_PRESC) begin
      rd_mux[PRESC_W-1:0] = presc;
    end else if (addr == OFF_IRQSR) begin
      rd_mux[NUM_CH-1:0] = ch_irq;
    end else if (is_ch) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (int'(ch_idx) == n) begin
          case (addr[3:0])
            OFF_CR:  rd_mux[3:0]       = ch_cr[n];
            OFF_SR:  rd_mux[1:0]       = ch_sr[n];
            OFF_CNT: rd_mux[CNT_W-1:0] = ch_cnt[n];
            OFF_CMP: rd_mux[CNT_W-1:0] = ch_cmp[n];
            default: rd_mux            = '0;
          endcase
        end
      end
    end
  end

  // Response channel: invalid offsets and writes return zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= req;
      err    <= req & ~addr_valid;
      if (req) begin
        rdata <= (addr_valid && !we) ? rd_mux : '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer
//   Self-checking bench for multi_timer (4 channels, 8-bit counters). A
//   behavioural model tracks the peripheral from the register-level rules and
//   is compared against the DUT on every falling edge; directed sequences add
//   hand-computed literal expectations.
module tb_multi_timer;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        gnt;
  logic        rvalid;
  logic        err;
  logic [31:0] rdata;
  logic        irq;
  logic [NCH-1:0] irq_vec;

  int n_checks = 0;
  int n_pass = 0;

  multi_timer #(.NUM_CH(NCH), .CNT_W(8), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .err(err), .rdata(rdata),
    .irq(irq), .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_run  [NCH];
  bit          m_per  [NCH];
  bit          m_ie   [NCH];
  bit          m_mtch [NCH];
  logic [7:0]  m_cnt  [NCH];
  logic [7:0]  m_cmp  [NCH];
  logic [15:0] m_presc;
  logic [15:0] m_pc;
  bit          m_rvalid;
  bit          m_err;
  logic [31:0] m_rdata;

  function automatic bit model_valid(input logic [11:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0 || ai == 4) return 1'b1;
    return (ai >= 256) && (ai < 256 + 16 * NCH) && (ai % 4 == 0);
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v;
    for (int n = 0; n < NCH; n++) v[n] = m_mtch[n] & m_ie[n];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int ai, ch, off;
    ai = int'(a);
    if (ai == 0) return 32'(m_presc);
    if (ai == 4) return 32'(model_irq());
    ch  = (ai - 256) / 16;
    off = ai % 16;
    case (off)
      0:       return 32'(m_ie[ch]) * 8 + 32'(m_per[ch]) * 4;
      4:       return 32'(m_mtch[ch]) * 2 + 32'(m_run[ch]);
      8:       return 32'(m_cnt[ch]);
      default: return 32'(m_cmp[ch]);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model_proc
    bit any_run, tick, valid, wr, hit, ctl, hw_match;
    int ch, off;
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        m_run[n] = 0; m_per[n] = 0; m_ie[n] = 0; m_mtch[n] = 0;
        m_cnt[n] = 0; m_cmp[n] = 0;
      end
      m_presc = 0; m_pc = 0; m_rvalid = 0; m_err = 0; m_rdata = 0;
    end else begin
      any_run = 0;
      for (int n = 0; n < NCH; n++) any_run |= m_run[n];
      tick  = any_run && (m_pc == m_presc);
      valid = model_valid(addr);
      m_rvalid = req;
      m_err    = req && !valid;
      if (req) m_rdata = (valid && !we) ? model_read(addr) : 32'd0;
      wr  = req && we && valid;
      ch  = (int'(addr) - 256) / 16;
      off = int'(addr) % 16;
      if (wr && addr == 12'h000) begin
        m_presc = wdata[15:0];
        m_pc = 0;
      end else if (any_run) begin
        m_pc = tick ? 16'd0 : m_pc + 16'd1;
      end
      for (int n = 0; n < NCH; n++) begin
        hit = wr && (int'(addr) >= 256) && (ch == n);
        ctl = hit && off == 0 && (wdata[0] || wdata[1]);
        hw_match = 0;
        if (ctl) begin
          if (wdata[1]) m_run[n] = 0;
          else begin m_run[n] = 1; m_cnt[n] = 0; end
        end else if (m_run[n] && tick) begin
          if (m_cnt[n] == m_cmp[n]) begin
            hw_match = 1;
            if (m_per[n]) m_cnt[n] = 0;
            else m_run[n] = 0;
          end else begin
            m_cnt[n] = m_cnt[n] + 8'd1;
          end
        end
        if (hw_match) m_mtch[n] = 1;
        else if (hit && off == 4 && wdata[1]) m_mtch[n] = 0;
        if (hit && off == 0) begin m_per[n] = wdata[2]; m_ie[n] = wdata[3]; end
        if (hit && off == 8) m_cnt[n] = wdata[7:0];
        if (hit && off == 12) m_cmp[n] = wdata[7:0];
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    checkOutput("model_gnt", 32'(gnt), 32'(req));
    checkOutput("model_rvalid", 32'(rvalid), 32'(m_rvalid));
    checkOutput("model_err", 32'(err), 32'(m_err));
    checkOutput("model_rdata", rdata, m_rdata);
    checkOutput("model_irq_vec", 32'(irq_vec), 32'(model_irq()));
    checkOutput("model_irq", 32'(irq), 32'(|model_irq()));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [11:0] a,
                               input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  task automatic busWrite(input logic [11:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
    step();
    applyStimulus(1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic busRead(input logic [11:0] a, output logic [31:0] d, output logic e);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
    step();
    d = rdata;
    e = err;
    applyStimulus(1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic waitIrq(input int budget, output int cycles);
    cycles = 0;
    while (irq !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic readCheck(input string name, input logic [11:0] a,
                           input logic [31:0] expected);
    logic [31:0] d;
    logic e;
    busRead(a, d, e);
    checkOutput(name, d, expected);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] d;
    logic e;
    int cyc;
    logic [31:0] cnt_seq [4];
    cnt_seq = '{32'd0, 32'd1, 32'd2, 32'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_rvalid", 32'(rvalid), 0);
    checkOutput("reset_irq", 32'(irq), 0);
    checkOutput("reset_irq_vec", 32'(irq_vec), 0);
    checkOutput("reset_rdata", rdata, 0);

    // Bus handshake and invalid offsets
    $display("[TB] bus handshake");
    applyStimulus(1'b1, 1'b0, 12'h00C, 32'h0);
    #1 checkOutput("gnt_follows_req", 32'(gnt), 1);
    step();
    checkOutput("bad_off_rvalid", 32'(rvalid), 1);
    checkOutput("bad_off_err", 32'(err), 1);
    checkOutput("bad_off_rdata", rdata, 0);
    applyStimulus(1'b0, 1'b0, 12'h000, 32'h0);
    #1 checkOutput("gnt_drops", 32'(gnt), 0);
    busRead(12'h140, d, e);
    checkOutput("bad_ch_err", 32'(e), 1);
    checkOutput("bad_ch_rdata", d, 0);
    busRead(12'h000, d, e);
    checkOutput("good_off_err", 32'(e), 0);

    // Single-shot channel 0, CMP=5, PRESC=0
    $display("[TB] single-shot");
    busWrite(12'h10C, 32'd5);
    busWrite(12'h000, 32'd0);
    busWrite(12'h100, 32'h9);
    repeat (5) step();
    checkOutput("ss_irq_early", 32'(irq), 0);
    step();
    checkOutput("ss_irq_t7", 32'(irq), 1);
    checkOutput("ss_irq_vec", 32'(irq_vec), 32'h1);
    readCheck("ss_sr", 12'h104, 32'h2);
    readCheck("ss_cnt", 12'h108, 32'd5);
    readCheck("ss_cr_trg_reads0", 12'h100, 32'h8);
    busWrite(12'h104, 32'h2);
    checkOutput("ss_w1c_irq", 32'(irq), 0);

    // Periodic channel 1 with PRESC=3
    $display("[TB] periodic");
    busWrite(12'h000, 32'd3);
    busWrite(12'h11C, 32'd2);
    busWrite(12'h110, 32'hD);
    waitIrq(40, cyc);
    checkOutput("per_first_match", 32'(cyc), 32'd12);
    checkOutput("per_irq_vec", 32'(irq_vec), 32'h2);
    busWrite(12'h114, 32'h2);
    checkOutput("per_cleared", 32'(irq), 0);
    waitIrq(40, cyc);
    checkOutput("per_period", 32'(cyc), 32'd11);
    readCheck("per_cnt_0", 12'h118, cnt_seq[0]);
    for (int i = 1; i < 4; i++) begin
      repeat (3) step();
      readCheck($sformatf("per_cnt_%0d", i), 12'h118, cnt_seq[i]);
    end
    busWrite(12'h110, 32'h2);
    busWrite(12'h114, 32'h2);
    busWrite(12'h000, 32'd0);

    // Channel independence, then halt before a match
    $display("[TB] independence");
    busWrite(12'h10C, 32'd3);
    busWrite(12'h12C, 32'd10);
    busWrite(12'h100, 32'h9);
    busWrite(12'h120, 32'h9);
    repeat (2) step();
    checkOutput("ind_none_yet", 32'(irq_vec), 32'h0);
    step();
    checkOutput("ind_ch0", 32'(irq_vec), 32'h1);
    repeat (7) step();
    checkOutput("ind_ch2_early", 32'(irq_vec), 32'h1);
    step();
    checkOutput("ind_ch0_ch2", 32'(irq_vec), 32'h5);
    busWrite(12'h104, 32'h2);
    busWrite(12'h124, 32'h2);
    busWrite(12'h120, 32'h9);
    repeat (3) step();
    busWrite(12'h120, 32'hA);
    readCheck("hlt_sr", 12'h124, 32'h0);
    readCheck("hlt_cnt", 12'h128, 32'd3);
    repeat (15) step();
    checkOutput("hlt_no_irq", 32'(irq_vec), 32'h0);
    readCheck("hlt_cnt_frozen", 12'h128, 32'd3);

    // Collisions
    $display("[TB] collisions");
    busWrite(12'h130, 32'h3);
    readCheck("trg_hlt_idle", 12'h134, 32'h0);
    busWrite(12'h100, 32'h9);
    repeat (3) step();
    busWrite(12'h104, 32'h2);
    checkOutput("w1c_vs_match", 32'(irq_vec), 32'h1);
    readCheck("w1c_vs_match_sr", 12'h104, 32'h2);
    busWrite(12'h104, 32'h2);
    busWrite(12'h10C, 32'd100);
    busWrite(12'h100, 32'h9);
    busWrite(12'h108, 32'd40);
    readCheck("cnt_wr_loaded", 12'h108, 32'd40);
    readCheck("cnt_wr_incr", 12'h108, 32'd41);
    busWrite(12'h100, 32'hA);

    // Wrap through 2^8 with upper wdata bits ignored
    $display("[TB] wrap");
    busWrite(12'h10C, 32'h1234_0003);
    readCheck("cmp_upper_ignored", 12'h10C, 32'd3);
    busWrite(12'h100, 32'h9);
    busWrite(12'h108, 32'd250);
    repeat (9) step();
    checkOutput("wrap_before", 32'(irq_vec), 32'h0);
    step();
    checkOutput("wrap_match", 32'(irq_vec), 32'h1);
    readCheck("wrap_cnt", 12'h108, 32'd3);

    // Asynchronous reset mid-count
    $display("[TB] reset mid-count");
    busWrite(12'h110, 32'hD);
    applyStimulus(1'b1, 1'b0, 12'h108, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 12'h000, 32'h0);
    checkOutput("pre_rst_irq", 32'(irq), 1);
    checkOutput("pre_rst_rvalid", 32'(rvalid), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_irq", 32'(irq), 0);
    checkOutput("rst_irq_vec", 32'(irq_vec), 0);
    checkOutput("rst_rvalid", 32'(rvalid), 0);
    checkOutput("rst_rdata", rdata, 0);
    repeat (2) step();
    rst = 1'b0;
    readCheck("rst_sr0", 12'h104, 32'h0);
    readCheck("rst_cnt1", 12'h118, 32'h0);
    readCheck("rst_presc", 12'h000, 32'h0);
    readCheck("rst_cmp0", 12'h10C, 32'h0);
    readCheck("rst_cr1", 12'h110, 32'h0);
    repeat (5) step();
    checkOutput("rst_no_glitch", 32'(irq), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
